cnt_host_seq: RTL

- Host-side sequencer and checker for the team's 8-bit loadable up-counter. It drives that counter's load data, set, enable and output-enable strobes, and reads back its gated output.
- Each run loads a start value and applies N increment cycles. It then checks two things: that the counter output reads zero while output-enable is low, and that the enabled output equals (start + N) mod 2^WIDTH.
- Results go to a per-run status plus saturating pass/fail tallies. The block sits in the test/BIST wrapper next to the counter.

---
 rtl/cnt_host_seq.sv | 111 +++++++++++
 1 files changed

// File: rtl/cnt_host_seq.sv
// Host-side sequencer/checker for the 8-bit loadable up-counter: loads a start
// value, applies N increments, then verifies the gated read-back (oe low and high).
module cnt_host_seq #(
  parameter int WIDTH   = 8,
  parameter int TALLY_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [WIDTH-1:0]   inc_cnt,
  output logic [WIDTH-1:0]   cnt_load_data,
  output logic               cnt_set,
  output logic               cnt_en,
  output logic               cnt_oe,
  input  logic [WIDTH-1:0]   cnt_rd_data,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   rd_val,
  output logic               err_val,
  output logic               err_z,
  output logic [TALLY_W-1:0] pass_cnt,
  output logic [TALLY_W-1:0] fail_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    INC  = 3'd2,
    ZCHK = 3'd3,
    READ = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
  localparam logic [TALLY_W-1:0] ONE_T   = TALLY_W'(1);
  localparam logic [TALLY_W-1:0] TAL_MAX = {TALLY_W{1'b1}};

  state_t           state;
  logic [WIDTH-1:0] ld_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] n_r;
  logic             z_bad;
  logic [WIDTH-1:0] exp_val;
  logic             val_bad;

  // Expected read-back wraps modulo 2^WIDTH by plain truncation.
  assign exp_val = ld_r + n_r;
  assign val_bad = (cnt_rd_data != exp_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ld_r     <= '0;
      rem_r    <= '0;
      n_r      <= '0;
      z_bad    <= 1'b0;
      rd_val   <= '0;
      err_val  <= 1'b0;
      err_z    <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ld_r  <= load_val;
            rem_r <= inc_cnt;
            n_r   <= inc_cnt;
            state <= LOAD;
          end
        end
        LOAD: state <= (rem_r != '0) ? INC : ZCHK;
        INC: begin
          rem_r <= rem_r - ONE_W;
          if (rem_r == ONE_W) state <= ZCHK;
        end
        ZCHK: begin
          z_bad <= (cnt_rd_data != '0);
          state <= READ;
        end
        READ: begin
          // Status and tallies commit together as the run enters DONE.
          rd_val  <= cnt_rd_data;
          err_val <= val_bad;
          err_z   <= z_bad;
          if (val_bad || z_bad) begin
            if (fail_cnt != TAL_MAX) fail_cnt <= fail_cnt + ONE_T;
          end else begin
            if (pass_cnt != TAL_MAX) pass_cnt <= pass_cnt + ONE_T;
          end
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cnt_load_data = ld_r;
  assign cnt_set       = (state == LOAD);
  assign cnt_en        = (state == INC);
  assign cnt_oe        = (state == READ);
  assign done          = (state == DONE);
  assign busy          = (state == LOAD) || (state == INC) ||
                         (state == ZCHK) || (state == READ);

endmodule
